mips_muldiv_unit: RTL
=====================

Name: mips_muldiv_unit

Overview:
Parametrised multi-cycle multiply/divide unit that extends the single-cycle datapath ALU with MIPS MULT/MULTU/DIV/DIVU and the HI/LO register pair. Sits beside the ALU in the execute stage. Hazard logic stalls on `busy`; MFHI/MFLO read `hi`/`lo` directly. Both multiply and divide are iterative radix-2 (one bit per cycle), so all operations have a fixed latency.

Parameters:
WIDTH, 32, operand and HI/LO width (>=4).
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
start  in  1  request an operation; sampled only when busy=0
op  in  2  00=MULT (signed), 01=MULTU, 10=DIV (signed), 11=DIVU
a  in  WIDTH  rs operand (multiplicand / dividend)
b  in  WIDTH  rt operand (multiplier / divisor)
hi_we  in  1  MTHI write strobe
lo_we  in  1  MTLO write strobe
wdata  in  WIDTH  MTHI/MTLO data
busy  out  1  operation in progress
done  out  1  one-cycle pulse; HI/LO hold the new result
div_by_zero  out  1  sticky flag: last DIV/DIVU had b=0; cleared on next accepted start
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (synchronous, active-high, `clk` edge with reset=1): state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0. Reset mid-operation aborts with no HI/LO update and no done pulse.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE: start=1 at edge k accepts the op.
  - Latch |a| and |b|; the absolute value is taken only for signed ops (unsigned otherwise).
  - Latch result signs: product/quotient sign = a[MSB]^b[MSB]; remainder sign = a[MSB].
  - Latch op. Clear counter. busy=1 from edge k.
- CALC: one iteration per edge, exactly WIDTH edges (k+1..k+WIDTH).
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract.
  - After WIDTH iterations -> FIX.
- FIX (edge k+WIDTH+1):
  - Apply sign correction (two's-complement negate).
  - Write hi/lo: multiply -> {hi,lo} = product; divide -> lo = quotient, hi = remainder.
  - Pulse done=1 for the cycle after this edge. busy=0. Return to IDLE.
- Total latency: accept at edge k, new results and done visible after edge k+WIDTH+1. The next start can be accepted in the done cycle.
- Arithmetic:
  - Signed results are truncated to WIDTH per half; quotient truncates toward zero; remainder has the dividend's sign.
  - Most-negative / -1: lo = 100..0, hi = 0. No trap.
- Divide by zero (b=0 on DIV/DIVU):
  - Same latency; hi = a (unmodified), lo = all ones.
  - div_by_zero=1 from the FIX edge until the next accepted start.
- start while busy=1: ignored. No queueing, no error.
- hi_we/lo_we:
  - Honoured only in IDLE with no start accepted that cycle; ignored otherwise.
  - Both strobes may write in the same cycle.
  - The write is visible on hi/lo the cycle after the edge.
- hi/lo hold their previous values throughout CALC. Intermediate values are never exposed.
- `op` and operands are don't-care except at the accept edge.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done exactly 33 edges after the accept edge; hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
- MULT a=-3 b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x1234 b=0 -> hi=0x00001234, lo=0xFFFFFFFF, div_by_zero=1. Next MULTU start clears div_by_zero.
- Second start plus hi_we (wdata=0xAAAA5555) 5 cycles into a MULTU 6*7 -> both ignored; result hi=0, lo=42. Then hi_we in IDLE -> hi=0xAAAA5555 next cycle.
- reset=1 ten cycles into a DIVU -> after the edge: busy=0, hi=lo=0, no done pulse. A new DIVU 100/7 then gives lo=14, hi=2.
- Re-run a MULT and a DIV case with WIDTH=8 -> latency 9 edges; e.g. MULT -128*-128: hi=0x40, lo=0x00.

Source files
------------

// File: rtl/mips_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with the MIPS HI/LO register pair.
// MULT/MULTU/DIV/DIVU take WIDTH+2 edges from accept to result (accept, WIDTH iterations, sign fix).
module mips_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       state_dbg
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    // Handshake: start is taken only on an edge where busy=0; done pulses for
    // exactly one cycle once hi/lo carry the result, and that cycle may accept again.

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               sign_pq_q, sign_pq_d;
    logic               sign_r_q, sign_r_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic               signed_op;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    always_comb begin
        signed_op = ~op[0];
        a_abs     = (signed_op && a[WIDTH-1]) ? -a : a;
        b_abs     = (signed_op && b[WIDTH-1]) ? -b : b;

        // opnd_q is the multiplicand for multiply and the divisor for divide.
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};

        prod_fix  = sign_pq_q ? -acc_q : acc_q;
        quot_fix  = sign_pq_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix   = sign_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        sign_pq_d = sign_pq_q;
        sign_r_d  = sign_r_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_CALC;
                    cnt_d     = '0;
                    is_div_d  = op[1];
                    sign_pq_d = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                    sign_r_d  = signed_op & a[WIDTH-1];
                    opnd_d    = op[1] ? b_abs : a_abs;
                    acc_d     = {{WIDTH{1'b0}}, (op[1] ? a_abs : b_abs)};
                    dbz_d     = 1'b0;
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            S_CALC: begin
                if (is_div_q) begin
                    if (!div_trial[WIDTH])
                        acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    else
                        acc_d = {acc_q[2*WIDTH-2:WIDTH-1], acc_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                // A zero divisor leaves |a| in the remainder, so the normal sign fix restores a.
                if (is_div_q) begin
                    hi_d  = rem_fix;
                    lo_d  = (opnd_q == '0) ? '1 : quot_fix;
                    dbz_d = (opnd_q == '0);
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            sign_pq_q <= 1'b0;
            sign_r_q  <= 1'b0;
            opnd_q    <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            sign_pq_q <= sign_pq_d;
            sign_r_q  <= sign_r_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign state_dbg   = state_q;

endmodule
